vector_mem_sequencer: RTL and testbench

VECTOR_MEM_SEQUENCER -- requirements
Module: vector_mem_sequencer

---
 rtl/vector_pkg.sv | 18 +
 rtl/lane_counter.sv | 28 ++
 rtl/vector_mem_sequencer.sv | 119 +++++++++++
 tb/tb_vector_mem_sequencer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/vector_pkg.sv
// Shared types and defaults for the vector memory sequencer.
// Latency: n/a (types only). Backpressure: n/a.
// Holds lane geometry defaults, the lane vector typedef and the FSM state encoding.
package vector_pkg;

    localparam int DEF_WIDTH        = 24;
    localparam int DEF_VECTOR_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH   = 24;

    typedef logic [DEF_VECTOR_WIDTH-1:0][DEF_WIDTH-1:0] lane_vec_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/lane_counter.sv
// Lane index counter with synchronous clear/increment and a last-lane flag.
// Latency: index updates one cycle after clr/inc; last is combinational from the index.
// Backpressure: none; the owner only pulses inc when a lane is accepted.
module lane_counter #(
    parameter int VECTOR_WIDTH = 8,
    parameter int LANE_W       = (VECTOR_WIDTH > 1) ? $clog2(VECTOR_WIDTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              inc,
    output logic [LANE_W-1:0] lane,
    output logic              last
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lane <= '0;
        end else if (clr) begin
            lane <= '0;
        end else if (inc) begin
            lane <= lane + 1'b1;
        end
    end

    assign last = (lane == LANE_W'(VECTOR_WIDTH - 1));

endmodule

// File: rtl/vector_mem_sequencer.sv
// Serialises a vector load/store into one scalar memory request per lane.
// Latency: zero-wait memory gives requests t+1..t+VECTOR_WIDTH after start at t, done at t+VECTOR_WIDTH+1.
// Backpressure: each lane request is held stable until mem_ack; start is ignored while busy.
module vector_mem_sequencer
    import vector_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int VECTOR_WIDTH = DEF_VECTOR_WIDTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic                                is_store,
    input  logic [ADDR_WIDTH-1:0]               base_addr,
    input  logic [VECTOR_WIDTH-1:0][WIDTH-1:0]  store_data,
    output logic                                mem_req,
    output logic                                mem_we,
    output logic [ADDR_WIDTH-1:0]               mem_addr,
    output logic [WIDTH-1:0]                    mem_wdata,
    input  logic [WIDTH-1:0]                    mem_rdata,
    input  logic                                mem_ack,
    output logic [VECTOR_WIDTH-1:0][WIDTH-1:0]  load_data,
    output logic                                busy,
    output logic                                done
);

    localparam int LANE_W = (VECTOR_WIDTH > 1) ? $clog2(VECTOR_WIDTH) : 1;

    seq_state_t                         state_q, state_d;
    logic                               is_store_q;
    logic [ADDR_WIDTH-1:0]              base_q;
    logic [VECTOR_WIDTH-1:0][WIDTH-1:0] store_q;
    logic [VECTOR_WIDTH-1:0][WIDTH-1:0] load_q;
    logic [LANE_W-1:0]                  lane;
    logic                               last_lane;
    logic                               capture;
    logic                               lane_ack;
    logic                               cnt_inc;

    lane_counter #(
        .VECTOR_WIDTH (VECTOR_WIDTH),
        .LANE_W       (LANE_W)
    ) u_lane_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (capture),
        .inc   (cnt_inc),
        .lane  (lane),
        .last  (last_lane)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            is_store_q <= 1'b0;
            base_q     <= '0;
            store_q    <= '0;
            load_q     <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                is_store_q <= is_store;
                base_q     <= base_addr;
                store_q    <= store_data;
            end
            if (lane_ack && !is_store_q) begin
                load_q[lane] <= mem_rdata;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        busy      = 1'b1;
        done      = 1'b0;
        capture   = 1'b0;
        lane_ack  = 1'b0;
        cnt_inc   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    capture = 1'b1;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                mem_req   = 1'b1;
                mem_we    = is_store_q;
                // address wraps modulo 2^ADDR_WIDTH by truncation
                mem_addr  = base_q + {{(ADDR_WIDTH-LANE_W){1'b0}}, lane};
                mem_wdata = store_q[lane];
                if (mem_ack) begin
                    lane_ack = 1'b1;
                    if (last_lane) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign load_data = load_q;

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Directed bench for vector_mem_sequencer: memory responder and checks run on the falling edge.
module tb_vector_mem_sequencer;

    localparam int W  = 24;
    localparam int VW = 8;
    localparam int AW = 24;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   start;
    logic                   is_store;
    logic [AW-1:0]          base_addr;
    logic [VW-1:0][W-1:0]   store_data;
    logic                   mem_req;
    logic                   mem_we;
    logic [AW-1:0]          mem_addr;
    logic [W-1:0]           mem_wdata;
    logic [W-1:0]           mem_rdata;
    logic                   mem_ack;
    logic [VW-1:0][W-1:0]   load_data;
    logic                   busy;
    logic                   done;

    int total = 0;
    int bad   = 0;
    int dcyc;

    vector_mem_sequencer #(
        .WIDTH        (W),
        .VECTOR_WIDTH (VW),
        .ADDR_WIDTH   (AW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .is_store   (is_store),
        .base_addr  (base_addr),
        .store_data (store_data),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .load_data  (load_data),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Runs one operation; the memory acks each lane after wt wait cycles.
    // inj_lane >= 0 pulses a conflicting start on that lane; rst_lane >= 0 resets on that lane.
    task automatic do_op(input logic st, input logic [AW-1:0] base, input int wt,
                         input int inj_lane, input int rst_lane, input bit start_in_done,
                         output int done_cyc);
        logic [VW-1:0][W-1:0] sd;
        logic [AW-1:0]        ea;
        int ln     = 0;
        int waited = 0;
        int cyc    = 0;
        bit fin    = 0;
        bit seen   = 0;
        done_cyc = -1;
        @(negedge clk);
        sd        = store_data;
        start     = 1'b1;
        is_store  = st;
        base_addr = base;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (!fin && cyc < 200) begin
            mem_ack = 1'b0;
            start   = 1'b0;
            if (ln < VW) begin
                ea = base + AW'(ln);
                check("req", 64'(mem_req), 64'd1);
                check("addr", 64'(mem_addr), 64'(ea));
                check("we", 64'(mem_we), 64'(st));
                if (st) check("wdata", 64'(mem_wdata), 64'(sd[ln]));
                check("busy", 64'(busy), 64'd1);
                if (ln == inj_lane && waited == 0) begin
                    start      = 1'b1;
                    is_store   = ~st;
                    base_addr  = 24'h777777;
                    store_data = '1;
                end
                if (ln == rst_lane) begin
                    rst_n = 1'b0;
                    @(negedge clk);
                    check("rst_req", 64'(mem_req), 64'd0);
                    check("rst_busy", 64'(busy), 64'd0);
                    check("rst_done", 64'(done), 64'd0);
                    for (int i = 0; i < VW; i++) check("rst_ld", 64'(load_data[i]), 64'd0);
                    rst_n = 1'b1;
                    for (int i = 0; i < 12; i++) begin
                        @(negedge clk);
                        if (done || mem_req) seen = 1;
                    end
                    check("rst_nodone", 64'(seen), 64'd0);
                    fin = 1;
                end else if (waited == wt) begin
                    mem_ack   = 1'b1;
                    mem_rdata = 24'h5A0000 + ea;
                    ln++;
                    waited = 0;
                end else begin
                    waited++;
                end
            end else begin
                check("done", 64'(done), 64'd1);
                check("done_req", 64'(mem_req), 64'd0);
                check("done_busy", 64'(busy), 64'd1);
                done_cyc = cyc;
                if (start_in_done) start = 1'b1;
                fin = 1;
            end
            if (!fin || rst_lane < 0) begin
                @(negedge clk);
                cyc++;
            end
        end
        mem_ack = 1'b0;
        start   = 1'b0;
        if (!fin) check("timeout", 64'd0, 64'd1);
        if (rst_lane < 0) begin
            check("post_done", 64'(done), 64'd0);
            check("post_busy", 64'(busy), 64'd0);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        is_store   = 1'b0;
        base_addr  = '0;
        store_data = '0;
        mem_ack    = 1'b0;
        mem_rdata  = '0;
        repeat (2) @(negedge clk);
        check("rs_req", 64'(mem_req), 64'd0);
        check("rs_we", 64'(mem_we), 64'd0);
        check("rs_addr", 64'(mem_addr), 64'd0);
        check("rs_wdata", 64'(mem_wdata), 64'd0);
        check("rs_busy", 64'(busy), 64'd0);
        check("rs_done", 64'(done), 64'd0);
        check("rs_ld", 64'(load_data), 64'd0);
        rst_n = 1'b1;

        // store, zero wait, plus a start attempted in the DONE cycle
        for (int i = 0; i < VW; i++) store_data[i] = 24'h00000A + 24'(i);
        do_op(1'b1, 24'h000100, 0, -1, -1, 1'b1, dcyc);
        check("st_lat", 64'(dcyc), 64'd9);
        check("st_ld", 64'(load_data), 64'd0);

        // load, zero wait
        store_data = '0;
        do_op(1'b0, 24'h000020, 0, -1, -1, 1'b0, dcyc);
        check("ld_lat", 64'(dcyc), 64'd9);
        for (int i = 0; i < VW; i++) check("ld_data", 64'(load_data[i]), 64'(24'h5A0020 + 24'(i)));

        // store with three wait cycles per lane
        for (int i = 0; i < VW; i++) store_data[i] = 24'hC00000 + 24'(i * 3);
        do_op(1'b1, 24'h000300, 3, -1, -1, 1'b0, dcyc);
        check("slow_lat", 64'(dcyc), 64'd33);
        check("slow_ld7", 64'(load_data[7]), 64'h5A0027);

        // load across the top of the address space
        do_op(1'b0, 24'hFFFFFE, 0, -1, -1, 1'b0, dcyc);
        check("wrap_ld0", 64'(load_data[0]), 64'h59FFFE);
        check("wrap_ld1", 64'(load_data[1]), 64'h59FFFF);
        check("wrap_ld2", 64'(load_data[2]), 64'h5A0000);
        check("wrap_ld7", 64'(load_data[7]), 64'h5A0005);

        // conflicting start on lane 3 must not disturb the running load
        store_data = '0;
        do_op(1'b0, 24'h000040, 0, 3, -1, 1'b0, dcyc);
        check("inj_lat", 64'(dcyc), 64'd9);
        for (int i = 0; i < VW; i++) check("inj_ld", 64'(load_data[i]), 64'(24'h5A0040 + 24'(i)));

        // ack while idle is ignored
        @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = 24'hABCDEF;
        repeat (2) @(negedge clk);
        mem_ack = 1'b0;
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_req", 64'(mem_req), 64'd0);
        check("idle_ld0", 64'(load_data[0]), 64'h5A0040);

        // reset during lane 4 of a load
        do_op(1'b0, 24'h000200, 0, -1, 4, 1'b0, dcyc);
        check("rst_lat", 64'(dcyc), 64'hFFFF_FFFF_FFFF_FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
